// File: rtl/bit_serial_adder.sv
// Bit-serial N-bit adder: one shared 1-bit full adder processes one bit per cycle, LSB first.
// Result, carry-out and signed overflow are registered when the last bit completes.

module adder_1 (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module bit_serial_adder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  a_sr, b_sr, ps;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          fa_s, fa_co;
  logic          last;

  adder_1 u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c_in  (carry),
    .sum   (fa_s),
    .c_out (fa_co)
  );

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = ADD;
      end
      ADD:     if (last) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // carry holds the carry into the current bit, so on the last bit it is the carry into the MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      ps       <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        ADD: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          ps    <= {fa_s, ps[N-1:1]};
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum      <= {fa_s, ps[N-1:1]};
            c_out    <= fa_co;
            overflow <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
